// File: rtl/uart_cipher_sequencer.sv
// uart_cipher_sequencer: hex command parser and encrypt sequencer between the UART FIFOs and the bfp engine.
// Define RESP_CRLF_EN to send a CR before every LF terminator.
module uart_cipher_sequencer #(
    parameter int HEX_CHARS      = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_BITS        = 13
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    input  logic        tx_full,
    output logic        tx_push,
    output logic [7:0]  tx_data,
    output logic [63:0] key_out,
    output logic [63:0] pt_out,
    output logic        start_encrypt,
    input  logic        done_encrypt,
    input  logic [63:0] ct_in,
    output logic        key_valid,
    output logic        key_loaded,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PT, START, WAIT_DONE, SEND_CT, SEND_EOL, SEND_ERR} state_t;
    state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [63:0] sh_q, sh_d, key_q, key_d, pt_q, pt_d, ct_q, ct_d;
    logic [7:0] err_q, err_d;
    logic [TO_BITS-1:0] to_q, to_d;
    logic start_q, start_d, key_valid_q, key_valid_d, key_loaded_q, key_loaded_d;
    logic is_dig, hex_ok, eol_last;
    logic [3:0] nib;
    logic [7:0] ct_ch, eol_ch;
    assign is_dig = rx_data inside {[8'h30:8'h39]};
    assign hex_ok = is_dig || rx_data inside {[8'h41:8'h46], [8'h61:8'h66]};
    assign nib = rx_data[3:0] + (is_dig ? 4'd0 : 4'd9);
    // ct_q shifts left on every accepted push, so the next nibble is always on top
    assign ct_ch = ct_q[63:60] > 4'd9 ? {4'h0, ct_q[63:60]} + 8'h37 : {4'h0, ct_q[63:60]} + 8'h30;
`ifdef RESP_CRLF_EN
    assign eol_ch = cnt_q[0] ? 8'h0A : 8'h0D;
    assign eol_last = cnt_q[0];
`else
    assign eol_ch = 8'h0A;
    assign eol_last = 1'b1;
`endif
    assign rx_pop = !reset && !rx_empty && state_q inside {IDLE, LOAD_KEY, LOAD_PT};
    assign tx_push = !reset && !tx_full && state_q inside {SEND_CT, SEND_EOL, SEND_ERR};
    assign tx_data = state_q == SEND_CT ? ct_ch : state_q == SEND_ERR ? err_q : state_q == SEND_EOL ? eol_ch : 8'h00;
    assign key_out = key_q;
    assign pt_out = pt_q;
    assign start_encrypt = start_q;
    assign key_valid = key_valid_q;
    assign key_loaded = key_loaded_q;
    assign busy = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sh_d = sh_q;
        key_d = key_q;
        pt_d = pt_q;
        ct_d = ct_q;
        err_d = err_q;
        to_d = to_q;
        start_d = start_q;
        key_valid_d = 1'b0;
        key_loaded_d = key_loaded_q;
        case (state_q)
            IDLE: if (rx_pop) begin
                if (rx_data == 8'h4B || rx_data == 8'h6B) begin
                    state_d = LOAD_KEY;
                    cnt_d = '0;
                end else if (rx_data == 8'h50 || rx_data == 8'h70) begin
                    state_d = key_loaded_q ? LOAD_PT : SEND_ERR;
                    err_d = 8'h21;
                    cnt_d = '0;
                end else if (!(rx_data inside {8'h20, 8'h0D, 8'h0A})) begin
                    state_d = SEND_ERR;
                    err_d = 8'h3F;
                end
            end
            LOAD_KEY, LOAD_PT: if (rx_pop) begin
                if (!hex_ok) begin
                    state_d = SEND_ERR;
                    err_d = 8'h3F;
                end else begin
                    sh_d = {sh_q[59:0], nib};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(HEX_CHARS - 1) && state_q == LOAD_KEY) begin
                        key_d = {sh_q[59:0], nib};
                        key_valid_d = 1'b1;
                        key_loaded_d = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q == 5'(HEX_CHARS - 1)) begin
                        pt_d = {sh_q[59:0], nib};
                        state_d = START;
                    end
                end
            end
            START: begin
                start_d = 1'b1;
                to_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: if (done_encrypt) begin
                ct_d = ct_in;
                start_d = 1'b0;
                cnt_d = '0;
                state_d = SEND_CT;
            end else if (to_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
                start_d = 1'b0;
                err_d = 8'h54;
                state_d = SEND_ERR;
            end else begin
                to_d = to_q + 1'b1;
            end
            SEND_CT: if (tx_push) begin
                ct_d = {ct_q[59:0], 4'h0};
                cnt_d = cnt_q == 5'(HEX_CHARS - 1) ? 5'd0 : cnt_q + 5'd1;
                state_d = cnt_q == 5'(HEX_CHARS - 1) ? SEND_EOL : SEND_CT;
            end
            SEND_EOL: if (tx_push) begin
                cnt_d = cnt_q + 5'd1;
                state_d = eol_last ? IDLE : SEND_EOL;
            end
            SEND_ERR: if (tx_push) begin
                cnt_d = '0;
                state_d = SEND_EOL;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            key_q <= '0;
            pt_q <= '0;
            ct_q <= '0;
            err_q <= '0;
            to_q <= '0;
            start_q <= 1'b0;
            key_valid_q <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            key_q <= key_d;
            pt_q <= pt_d;
            ct_q <= ct_d;
            err_q <= err_d;
            to_q <= to_d;
            start_q <= start_d;
            key_valid_q <= key_valid_d;
            key_loaded_q <= key_loaded_d;
        end
    end
endmodule
